// File: rtl/calculator_keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce.
// Emits a one-cycle key_valid per accepted press and key_down while held.
module calculator_keypad_scan #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {StIdle, StDebnc, StHeld, StRel} state_e;

    logic [3:0]      col_meta_q, col_sync_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      row_q;
    logic [3:0]      key_row_q;
    logic [1:0]      acc_cnt_q, acc_cnt_d;
    logic [3:0]      acc_code_q, acc_code_d;
    logic            res_valid_q, res_key_q;
    logic [3:0]      res_code_q;
    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_down_q, key_down_d;

    logic            slot_end;
    logic [3:0]      low;
    logic [2:0]      low_n, acc_sum;
    logic [1:0]      col_idx;
    logic [1:0]      row_nxt;

    assign slot_end = (div_q == DivLast);
    assign low      = ~col_sync_q;
    assign row_nxt  = row_q + 2'd1;

    // Accumulator saturates at 2: any frame with two or more low columns is MULTI.
    always_comb begin
        low_n   = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        acc_sum = {1'b0, acc_cnt_q} + low_n;
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (low[i]) col_idx = 2'(i);
        end
        acc_cnt_d  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        acc_code_d = acc_code_q;
        if (acc_cnt_q == 2'd0 && low_n == 3'd1) acc_code_d = {row_q, col_idx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            div_q       <= '0;
            row_q       <= 2'd0;
            key_row_q   <= 4'b1110;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'd0;
            res_valid_q <= 1'b0;
            res_key_q   <= 1'b0;
            res_code_q  <= 4'd0;
        end else begin
            col_meta_q  <= key_col;
            col_sync_q  <= col_meta_q;
            res_valid_q <= 1'b0;
            if (slot_end) begin
                div_q     <= '0;
                row_q     <= row_nxt;
                key_row_q <= ~(4'b0001 << row_nxt);
                if (row_q == 2'd3) begin
                    res_valid_q <= 1'b1;
                    res_key_q   <= (acc_cnt_d == 2'd1);
                    res_code_q  <= acc_code_d;
                    acc_cnt_q   <= 2'd0;
                    acc_code_q  <= 4'd0;
                end else begin
                    acc_cnt_q  <= acc_cnt_d;
                    acc_code_q <= acc_code_d;
                end
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (res_valid_q) begin
            unique case (state_q)
                StIdle: begin
                    if (res_key_q) begin
                        cand_d = res_code_q;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d     = StHeld;
                            key_code_d  = res_code_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                        end else begin
                            cnt_d   = CntW'(1);
                            state_d = StDebnc;
                        end
                    end
                end
                StDebnc: begin
                    if (!res_key_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (res_code_q != cand_q) begin
                        cand_d = res_code_q;
                        cnt_d  = CntW'(1);
                    end else if (cnt_inc == CntLast) begin
                        state_d     = StHeld;
                        cnt_d       = cnt_inc;
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHeld: begin
                    if (!res_key_q) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d    = StIdle;
                            key_down_d = 1'b0;
                        end else begin
                            cnt_d   = CntW'(1);
                            state_d = StRel;
                        end
                    end
                end
                StRel: begin
                    if (res_key_q) begin
                        state_d = StHeld;
                    end else if (cnt_inc == CntLast) begin
                        state_d    = StIdle;
                        cnt_d      = '0;
                        key_down_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign key_row   = key_row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_calculator_keypad_scan.sv
// Bench for calculator_keypad_scan: a keypad matrix model drives the columns and a
// frame-history reference model predicts key_valid/key_code/key_down every cycle.
module tb_calculator_keypad_scan;

    localparam int SD = 4;
    localparam int D  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_col, key_row, key_code;
    logic       key_valid, key_down;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int frame_no = 0;

    int         hist[$];
    bit         m_down, prev_down, last_valid;
    logic [3:0] m_code, prev_code;

    calculator_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(D)) dut (
        .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to its row strobe.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
    end

    // Reference: accept when the last D frames are the same single key; release
    // when the last D frames are all without a single key.
    function automatic void model_frame(input logic [15:0] mask);
        int  res;
        bit  same;
        res = -1;
        if ($countones(mask) == 1)
            for (int b = 0; b < 16; b++) if (mask[b]) res = b;
        hist.push_back(res);
        last_valid = 1'b0;
        if (hist.size() >= D) begin
            same = 1'b1;
            for (int j = 1; j < D; j++) if (hist[hist.size()-1-j] != res) same = 1'b0;
            if (same && !m_down && res >= 0) begin
                m_down = 1'b1; m_code = 4'(res); last_valid = 1'b1; hist.delete();
            end else if (same && m_down && res < 0) begin
                m_down = 1'b0; hist.delete();
            end
        end
    endfunction

    task automatic run_frame(input logic [15:0] mask);
        logic [3:0] erow, ecode;
        logic       evalid, edown;
        pressed = mask;
        for (int i = 0; i < 16; i++) begin
            erow   = ~(4'b0001 << (i / 4));
            evalid = (i == 1) && last_valid;
            ecode  = (i == 0) ? prev_code : m_code;
            edown  = (i == 0) ? prev_down : m_down;
            checks += 4;
            if (key_row !== erow) begin
                errors++;
                $display("FAIL key_row frame %0d cyc %0d got %b want %b", frame_no, i, key_row, erow);
            end
            if (key_valid !== evalid) begin
                errors++;
                $display("FAIL key_valid frame %0d cyc %0d got %b want %b", frame_no, i, key_valid, evalid);
            end
            if (key_code !== ecode) begin
                errors++;
                $display("FAIL key_code frame %0d cyc %0d got %h want %h", frame_no, i, key_code, ecode);
            end
            if (key_down !== edown) begin
                errors++;
                $display("FAIL key_down frame %0d cyc %0d got %b want %b", frame_no, i, key_down, edown);
            end
            if (key_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        prev_code = m_code;
        prev_down = m_down;
        model_frame(mask);
        frame_no++;
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n);
        for (int k = 0; k < n; k++) run_frame(mask);
    endtask

    task automatic check_pulses(input string name, input int want);
        checks++;
        if (pulses !== want) begin
            errors++;
            $display("FAIL %s pulses got %0d want %0d", name, pulses, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({key_row, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got row=%b code=%h v=%b d=%b want row=1110 code=0 v=0 d=0",
                     key_row, key_code, key_valid, key_down);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        m_down = 0; prev_down = 0; last_valid = 0;
        m_code = 0; prev_code = 0;
    endtask

    task automatic test_reset();
        pressed = 16'h0;
        do_reset();
        pulses = 0;
        run_frames(16'h0, 2);
        check_pulses("idle_no_pulse", 0);
    endtask

    task automatic test_press_release();
        pulses = 0;
        run_frames(16'h0200, 5);
        check_pulses("press_9", 1);
        checks++;
        if (key_code !== 4'h9 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL press_9_state got code=%h down=%b want code=9 down=1", key_code, key_down);
        end
        run_frames(16'h0, 4);
        checks++;
        if (key_code !== 4'h9 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL release_9_state got code=%h down=%b want code=9 down=0", key_code, key_down);
        end
    endtask

    task automatic test_bounce();
        pulses = 0;
        run_frame(16'h0008);
        run_frame(16'h0);
        run_frame(16'h0008);
        run_frames(16'h0, 3);
        check_pulses("bounce", 0);
    endtask

    task automatic test_multi();
        pulses = 0;
        run_frames(16'h0050, 6);
        check_pulses("multi_held", 0);
        run_frames(16'h0010, 4);
        check_pulses("multi_resolved", 1);
        checks++;
        if (key_code !== 4'h4) begin
            errors++;
            $display("FAIL multi_code got %h want 4", key_code);
        end
        run_frames(16'h0, 4);
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        run_frames(16'h8000, 4);
        run_frames(16'h0001, 4);
        check_pulses("held_change", 1);
        checks++;
        if (key_code !== 4'hF) begin
            errors++;
            $display("FAIL held_change_code got %h want f", key_code);
        end
        run_frames(16'h0, 4);
        run_frames(16'h0001, 4);
        check_pulses("repress_0", 2);
        checks++;
        if (key_code !== 4'h0 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL repress_0_state got code=%h down=%b want code=0 down=1", key_code, key_down);
        end
        run_frames(16'h0, 4);
    endtask

    task automatic test_mid_reset();
        pulses = 0;
        run_frame(16'h0020);
        repeat (8) @(negedge clk);
        do_reset();
        run_frames(16'h0020, 3);
        check_pulses("reset_no_early", 0);
        run_frame(16'h0020);
        check_pulses("reset_then_press", 1);
        checks++;
        if (key_code !== 4'h5) begin
            errors++;
            $display("FAIL reset_press_code got %h want 5", key_code);
        end
        run_frames(16'h0, 4);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int          kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            mask = 16'h0;
            if (kind >= 4) mask[$urandom_range(0, 15)] = 1'b1;
            if (kind >= 8) mask[$urandom_range(0, 15)] = 1'b1;
            run_frames(mask, $urandom_range(1, 5));
        end
        run_frames(16'h0, 4);
    endtask

    initial begin
        rst = 1'b1;
        pressed = 16'h0;
        test_reset();
        test_press_release();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
